// File: rtl/ecc_pkg.sv
// Shared types and constants for the read-return ECC scrub stage.
//   ECC_DW / ECC_CW : data and codeword widths of the 11-to-16 SECDED code.
//   HAM_MASKS       : Hamming parity coverage over codeword bits [14:0]; bit 15 is the
//                     overall parity bit.
//   scrub_state_e   : write-back FSM states.
//   rd_word_t       : registered output word (data + error flags + location).
package ecc_pkg;

    localparam int unsigned ECC_DW = 11;
    localparam int unsigned ECC_CW = 16;

    // Entry b covers every Hamming position (index + 1) whose bit b is set.
    localparam logic [3:0][14:0] HAM_MASKS = {15'h7F80, 15'h7878, 15'h6666, 15'h5555};

    typedef enum logic {
        StIdle  = 1'b0,
        StWbReq = 1'b1
    } scrub_state_e;

    typedef struct packed {
        logic [ECC_DW-1:0] data;
        logic              ce;
        logic              ue;
        logic [3:0]        loc;
    } rd_word_t;

endpackage

// File: rtl/ecc_11to16.sv
// Combinational SECDED (extended Hamming) encoder and decoder, 11 data bits to 16.
//   enc_in/enc_out          : data in, clean codeword out.
//   dec_in/dec_out          : raw codeword in, corrected data out (raw data on UE).
//   err_correct             : single-bit error corrected.
//   err_uncorrect           : double-bit error detected.
//   err_location            : codeword bit index of the corrected bit, 4'hF when the
//                             overall parity bit itself was flipped, 0 otherwise.
module ecc_11to16
    import ecc_pkg::*;
(
    input  logic [ECC_DW-1:0] enc_in,
    output logic [ECC_CW-1:0] enc_out,
    input  logic [ECC_CW-1:0] dec_in,
    output logic [ECC_DW-1:0] dec_out,
    output logic              err_correct,
    output logic              err_uncorrect,
    output logic [3:0]        err_location
);

    logic [14:0] enc_ham;
    logic [14:0] dec_fix;
    logic [3:0]  syndrome;
    logic        parity_err;

    // Parity positions start at zero and no mask covers another parity bit,
    // so each parity can be computed over the partially built word.
    always_comb begin
        enc_ham       = '0;
        enc_ham[2]    = enc_in[0];
        enc_ham[6:4]  = enc_in[3:1];
        enc_ham[14:8] = enc_in[10:4];
        enc_ham[0]    = ^(enc_ham & HAM_MASKS[0]);
        enc_ham[1]    = ^(enc_ham & HAM_MASKS[1]);
        enc_ham[3]    = ^(enc_ham & HAM_MASKS[2]);
        enc_ham[7]    = ^(enc_ham & HAM_MASKS[3]);
        enc_out       = {^enc_ham, enc_ham};
    end

    always_comb begin
        syndrome = '0;
        for (int b = 0; b < 4; b++) begin
            syndrome[b] = ^(dec_in[14:0] & HAM_MASKS[b]);
        end
        parity_err    = ^dec_in;
        err_correct   = parity_err;
        err_uncorrect = !parity_err && (syndrome != 4'd0);
        err_location  = 4'd0;
        dec_fix       = dec_in[14:0];
        if (parity_err) begin
            if (syndrome == 4'd0) begin
                err_location = 4'hF;
            end else begin
                err_location = syndrome - 4'd1;
                dec_fix      = dec_in[14:0] ^ (15'd1 << err_location);
            end
        end
        dec_out = {dec_fix[14:8], dec_fix[6:4], dec_fix[2]};
    end

endmodule

// File: rtl/ecc_rd_scrub.sv
// Read-return stage: decodes SECDED codewords, registers corrected data with error
// flags onto an output stream, counts CE/UE events, logs the first error and issues
// one scrub write-back of the clean codeword for each correctable error.
//   in_*        : codeword + address input stream (valid/ready).
//   out_*       : corrected data stream with ce/ue flags and error location.
//   scrub_en    : sampled at accept; enables write-back on CE.
//   wb_*        : scrub write request (valid/ready), address and clean codeword.
//   cnt_clr     : synchronous clear of counters and first-error log.
//   ce_cnt/ue_cnt, first_err_* : saturating counters and first-error log.
module ecc_rd_scrub
    import ecc_pkg::*;
#(
    parameter int unsigned AW    = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AW-1:0]     in_addr,
    input  logic [ECC_CW-1:0] in_cw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ECC_DW-1:0] out_data,
    output logic              out_ce,
    output logic              out_ue,
    output logic [3:0]        out_loc,
    input  logic              scrub_en,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [AW-1:0]     wb_addr,
    output logic [ECC_CW-1:0] wb_cw,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  ce_cnt,
    output logic [CNT_W-1:0]  ue_cnt,
    output logic              first_err_valid,
    output logic [AW-1:0]     first_err_addr,
    output logic              first_err_ue,
    output logic [3:0]        first_err_loc
);

    logic [ECC_DW-1:0] dec_data;
    logic [ECC_CW-1:0] clean_cw;
    logic              dec_ce;
    logic              dec_ue;
    logic [3:0]        dec_loc;

    ecc_11to16 u_ecc (
        .enc_in       (dec_data),
        .enc_out      (clean_cw),
        .dec_in       (in_cw),
        .dec_out      (dec_data),
        .err_correct  (dec_ce),
        .err_uncorrect(dec_ue),
        .err_location (dec_loc)
    );

    scrub_state_e      state_q, state_d;
    logic              out_valid_q;
    rd_word_t          out_q;
    logic [AW-1:0]     wb_addr_q;
    logic [ECC_CW-1:0] wb_cw_q;
    logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d, ue_cnt_q, ue_cnt_d;
    logic              log_valid_q, log_ue_q;
    logic [AW-1:0]     log_addr_q;
    logic [3:0]        log_loc_q;
    logic              accept, wb_load, ce_evt, ue_evt, log_capture;

    // Gated by rst_n so nothing is accepted while reset is held.
    assign in_ready = rst_n && (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign ce_evt   = accept && dec_ce;
    assign ue_evt   = accept && dec_ue;
    // A clear re-arms the log, so a coincident event is captured.
    assign log_capture = (ce_evt || ue_evt) && (cnt_clr || !log_valid_q);

    always_comb begin
        state_d  = state_q;
        wb_load  = 1'b0;
        wb_valid = 1'b0;
        case (state_q)
            StIdle: begin
                if (ce_evt && scrub_en) begin
                    state_d = StWbReq;
                    wb_load = 1'b1;
                end
            end
            StWbReq: begin
                wb_valid = 1'b1;
                if (wb_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ce_cnt_d = ce_cnt_q;
        ue_cnt_d = ue_cnt_q;
        if (cnt_clr) begin
            ce_cnt_d = CNT_W'(ce_evt);
            ue_cnt_d = CNT_W'(ue_evt);
        end else begin
            if (ce_evt && (ce_cnt_q != '1)) ce_cnt_d = ce_cnt_q + 1'b1;
            if (ue_evt && (ue_cnt_q != '1)) ue_cnt_d = ue_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            wb_addr_q   <= '0;
            wb_cw_q     <= '0;
            ce_cnt_q    <= '0;
            ue_cnt_q    <= '0;
            log_valid_q <= 1'b0;
            log_ue_q    <= 1'b0;
            log_addr_q  <= '0;
            log_loc_q   <= '0;
        end else begin
            state_q  <= state_d;
            ce_cnt_q <= ce_cnt_d;
            ue_cnt_q <= ue_cnt_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_q       <= '{data: dec_data, ce: dec_ce, ue: dec_ue, loc: dec_loc};
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (wb_load) begin
                wb_addr_q <= in_addr;
                wb_cw_q   <= clean_cw;
            end
            if (log_capture) begin
                log_valid_q <= 1'b1;
                log_ue_q    <= dec_ue;
                log_addr_q  <= in_addr;
                log_loc_q   <= dec_loc;
            end else if (cnt_clr) begin
                log_valid_q <= 1'b0;
                log_ue_q    <= 1'b0;
                log_addr_q  <= '0;
                log_loc_q   <= '0;
            end
        end
    end

    assign out_valid       = out_valid_q;
    assign out_data        = out_q.data;
    assign out_ce          = out_q.ce;
    assign out_ue          = out_q.ue;
    assign out_loc         = out_q.loc;
    assign wb_addr         = wb_addr_q;
    assign wb_cw           = wb_cw_q;
    assign ce_cnt          = ce_cnt_q;
    assign ue_cnt          = ue_cnt_q;
    assign first_err_valid = log_valid_q;
    assign first_err_addr  = log_addr_q;
    assign first_err_ue    = log_ue_q;
    assign first_err_loc   = log_loc_q;

endmodule

// File: tb/tb_ecc_rd_scrub.sv
module tb_ecc_rd_scrub;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0, scrub_en = 1'b0;
    logic          wb_ready = 1'b0, cnt_clr = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [15:0]   in_cw = '0;

    logic          in_ready, out_valid, out_ce, out_ue, wb_valid, first_err_valid, first_err_ue;
    logic [10:0]   out_data;
    logic [3:0]    out_loc, first_err_loc;
    logic [AW-1:0] wb_addr, first_err_addr;
    logic [15:0]   wb_cw, ce_cnt, ue_cnt;

    logic          s_in_ready, s_out_valid, s_out_ce, s_out_ue, s_wb_valid, s_fev, s_feue;
    logic [10:0]   s_out_data;
    logic [3:0]    s_out_loc, s_feloc;
    logic [AW-1:0] s_wb_addr, s_feaddr;
    logic [15:0]   s_wb_cw;
    logic [1:0]    s_ce_cnt, s_ue_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ecc_rd_scrub #(.AW(AW), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_cw(in_cw), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ce(out_ce), .out_ue(out_ue), .out_loc(out_loc),
        .scrub_en(scrub_en), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_cw(wb_cw), .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt),
        .first_err_valid(first_err_valid), .first_err_addr(first_err_addr),
        .first_err_ue(first_err_ue), .first_err_loc(first_err_loc)
    );

    // Narrow-counter copy sharing all inputs, used for saturation checks.
    ecc_rd_scrub #(.AW(AW), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_addr(in_addr), .in_cw(in_cw), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_ce(s_out_ce), .out_ue(s_out_ue), .out_loc(s_out_loc),
        .scrub_en(scrub_en), .wb_valid(s_wb_valid), .wb_ready(wb_ready), .wb_addr(s_wb_addr),
        .wb_cw(s_wb_cw), .cnt_clr(cnt_clr), .ce_cnt(s_ce_cnt), .ue_cnt(s_ue_cnt),
        .first_err_valid(s_fev), .first_err_addr(s_feaddr),
        .first_err_ue(s_feue), .first_err_loc(s_feloc)
    );

    // Reference code: Hamming positions 1..15 (bit index = position - 1), powers of two
    // are parity, bit 15 is overall parity.
    function automatic logic [15:0] m_enc(input logic [10:0] d);
        logic [15:0] cw;
        int k;
        cw = '0;
        k = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            int pp;
            logic par;
            pp = 1 << b;
            par = 1'b0;
            for (int p = 1; p < 16; p++) if ((p & pp) != 0 && p != pp) par ^= cw[p-1];
            cw[pp-1] = par;
        end
        cw[15] = ^cw[14:0];
        return cw;
    endfunction

    function automatic logic [10:0] m_extract(input logic [15:0] cw);
        logic [10:0] d;
        int k;
        d = '0;
        k = 0;
        for (int p = 1; p < 16; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = cw[p-1];
                k++;
            end
        end
        return d;
    endfunction

    // Nearest-codeword decode: exact match is clean, one flip away is CE, else UE.
    function automatic void m_dec(input logic [15:0] cw, output logic [10:0] d,
                                  output logic ce, output logic ue, output logic [3:0] loc);
        logic [15:0] t;
        d = m_extract(cw);
        ce = 1'b0;
        ue = 1'b0;
        loc = 4'd0;
        if (m_enc(d) != cw) begin
            ue = 1'b1;
            for (int i = 0; i < 16; i++) begin
                t = cw ^ (16'd1 << i);
                if (m_enc(m_extract(t)) == t) begin
                    ce = 1'b1;
                    ue = 1'b0;
                    d = m_extract(t);
                    loc = (i == 15) ? 4'hF : 4'(i);
                end
            end
        end
    endfunction

    // Present a word and wait (bounded) for it to be accepted; ends 1 ns after that edge.
    task automatic push(input logic [AW-1:0] a, input logic [15:0] cw, input logic se);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_addr = a;
        in_cw = cw;
        scrub_en = se;
        #1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_timeout in_ready=%b want 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks += 6;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %b want 0", wb_valid); end
        if (ce_cnt !== 16'd0) begin errors++; $display("FAIL rst_ce_cnt got %0d want 0", ce_cnt); end
        if (ue_cnt !== 16'd0) begin errors++; $display("FAIL rst_ue_cnt got %0d want 0", ue_cnt); end
        if (first_err_valid !== 1'b0) begin errors++; $display("FAIL rst_log got %b want 0", first_err_valid); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
    endtask

    task automatic test_clean();
        push(10'd3, 16'h8007, 1'b1);
        checks += 6;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL clean_valid got %b want 1", out_valid); end
        if (out_data !== 11'h001) begin errors++; $display("FAIL clean_data got %h want 001", out_data); end
        if (out_ce !== 1'b0 || out_ue !== 1'b0) begin errors++; $display("FAIL clean_flags got ce=%b ue=%b want 0 0", out_ce, out_ue); end
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL clean_wb got %b want 0", wb_valid); end
        if (ce_cnt !== 16'd0 || ue_cnt !== 16'd0) begin errors++; $display("FAIL clean_cnt got %0d/%0d want 0/0", ce_cnt, ue_cnt); end
        if (first_err_valid !== 1'b0) begin errors++; $display("FAIL clean_log got %b want 0", first_err_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_drop got %b want 0", out_valid); end
    endtask

    task automatic test_single();
        wb_ready = 1'b0;
        push(10'd5, 16'h8003, 1'b1);
        checks += 7;
        if (out_data !== 11'h001 || out_ce !== 1'b1 || out_ue !== 1'b0) begin errors++; $display("FAIL single_out got d=%h ce=%b ue=%b want 001 1 0", out_data, out_ce, out_ue); end
        if (out_loc !== 4'd2) begin errors++; $display("FAIL single_loc got %0d want 2", out_loc); end
        if (wb_valid !== 1'b1 || wb_addr !== 10'd5) begin errors++; $display("FAIL single_wb got v=%b a=%0d want 1 5", wb_valid, wb_addr); end
        if (wb_cw !== 16'h8007) begin errors++; $display("FAIL single_wb_cw got %h want 8007", wb_cw); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL single_ready got %b want 0", in_ready); end
        if (ce_cnt !== 16'd1) begin errors++; $display("FAIL single_ce_cnt got %0d want 1", ce_cnt); end
        if (first_err_valid !== 1'b1 || first_err_addr !== 10'd5 || first_err_loc !== 4'd2 || first_err_ue !== 1'b0)
            begin errors++; $display("FAIL single_log got v=%b a=%0d l=%0d ue=%b want 1 5 2 0", first_err_valid, first_err_addr, first_err_loc, first_err_ue); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b0 || wb_valid !== 1'b1) begin errors++; $display("FAIL single_hold got rdy=%b wb=%b want 0 1", in_ready, wb_valid); end
        end
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        wb_ready = 1'b0;
        checks++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL single_done got wb=%b rdy=%b want 0 1", wb_valid, in_ready); end
    endtask

    task automatic test_double();
        push(10'd7, 16'h0030, 1'b1);
        checks += 4;
        if (out_ue !== 1'b1 || out_ce !== 1'b0) begin errors++; $display("FAIL double_flags got ce=%b ue=%b want 0 1", out_ce, out_ue); end
        if (ue_cnt !== 16'd1) begin errors++; $display("FAIL double_ue_cnt got %0d want 1", ue_cnt); end
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL double_wb got %b want 0", wb_valid); end
        if (first_err_addr !== 10'd5 || first_err_ue !== 1'b0) begin errors++; $display("FAIL double_log got a=%0d ue=%b want 5 0", first_err_addr, first_err_ue); end
    endtask

    task automatic test_parity();
        push(10'd9, 16'h8000, 1'b1);
        checks += 3;
        if (out_data !== 11'h000 || out_ce !== 1'b1 || out_loc !== 4'hF) begin errors++; $display("FAIL parity_out got d=%h ce=%b loc=%h want 000 1 f", out_data, out_ce, out_loc); end
        if (wb_valid !== 1'b1 || wb_cw !== 16'h0000 || wb_addr !== 10'd9) begin errors++; $display("FAIL parity_wb got v=%b cw=%h a=%0d want 1 0000 9", wb_valid, wb_cw, wb_addr); end
        if (ce_cnt !== 16'd2) begin errors++; $display("FAIL parity_ce_cnt got %0d want 2", ce_cnt); end
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        wb_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [15:0] cw_b;
        cw_b = m_enc(11'h155);
        out_ready = 1'b0;
        push(10'd11, m_enc(11'h2A5), 1'b0);
        in_valid = 1'b1;
        in_addr = 10'd12;
        in_cw = cw_b;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks += 2;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", in_ready); end
            if (out_valid !== 1'b1 || out_data !== 11'h2A5 || out_ce !== 1'b0 || out_ue !== 1'b0)
                begin errors++; $display("FAIL bp_hold got v=%b d=%h want 1 2a5", out_valid, out_data); end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 11'h155) begin errors++; $display("FAIL bp_next got v=%b d=%h want 1 155", out_valid, out_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_saturation();
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checks++;
        if (ce_cnt !== 16'd0 || s_ce_cnt !== 2'd0 || first_err_valid !== 1'b0)
            begin errors++; $display("FAIL clr got ce=%0d sce=%0d log=%b want 0 0 0", ce_cnt, s_ce_cnt, first_err_valid); end
        for (int i = 0; i < 5; i++) push(10'(20 + i), 16'h8003, 1'b0);
        checks += 3;
        if (s_ce_cnt !== 2'd3) begin errors++; $display("FAIL sat_ce got %0d want 3", s_ce_cnt); end
        if (ce_cnt !== 16'd5) begin errors++; $display("FAIL wide_ce got %0d want 5", ce_cnt); end
        if (wb_valid !== 1'b0 || first_err_addr !== 10'd20) begin errors++; $display("FAIL sat_misc got wb=%b a=%0d want 0 20", wb_valid, first_err_addr); end
        cnt_clr = 1'b1;
        push(10'd30, 16'h8003, 1'b0);
        cnt_clr = 1'b0;
        checks += 3;
        if (ce_cnt !== 16'd1 || s_ce_cnt !== 2'd1) begin errors++; $display("FAIL clr_evt_ce got %0d/%0d want 1/1", ce_cnt, s_ce_cnt); end
        if (ue_cnt !== 16'd0) begin errors++; $display("FAIL clr_evt_ue got %0d want 0", ue_cnt); end
        if (first_err_valid !== 1'b1 || first_err_addr !== 10'd30) begin errors++; $display("FAIL clr_evt_log got v=%b a=%0d want 1 30", first_err_valid, first_err_addr); end
    endtask

    task automatic test_random();
        logic        m_ov, m_ce_o, m_ue_o, m_wb, m_lv, m_lue;
        logic [10:0] m_d;
        logic [3:0]  m_loc, m_lloc;
        logic [AW-1:0] m_wba, m_la;
        logic [15:0] m_wbcw;
        int          m_ce, m_ue;
        logic [10:0] dd;
        logic        dce, due, m_rdy, acc;
        logic [3:0]  dloc;
        int          sel, b1, b2;
        // Drain and clear so the model starts from a known empty state.
        in_valid = 1'b0;
        out_ready = 1'b1;
        wb_ready = 1'b1;
        cnt_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        m_ov = 0; m_wb = 0; m_lv = 0; m_ce = 0; m_ue = 0;
        m_d = '0; m_ce_o = 0; m_ue_o = 0; m_loc = '0;
        m_wba = '0; m_wbcw = '0; m_la = '0; m_lue = 0; m_lloc = '0;
        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom % 4) != 0;
            in_addr = 10'($urandom);
            dd = 11'($urandom);
            sel = $urandom % 4;
            b1 = $urandom % 16;
            b2 = (b1 + 1 + ($urandom % 15)) % 16;
            case (sel)
                0: in_cw = m_enc(dd);
                1: in_cw = m_enc(dd) ^ (16'd1 << b1);
                2: in_cw = m_enc(dd) ^ (16'd1 << b1) ^ (16'd1 << b2);
                default: in_cw = 16'($urandom);
            endcase
            scrub_en = $urandom % 2;
            out_ready = ($urandom % 10) < 7;
            wb_ready = $urandom % 2;
            cnt_clr = ($urandom % 16) == 0;
            #1;
            m_rdy = !m_wb && (!m_ov || out_ready);
            checks++;
            if (in_ready !== m_rdy) begin errors++; $display("FAIL rnd_ready c=%0d got %b want %b", c, in_ready, m_rdy); end
            acc = in_valid && m_rdy;
            m_dec(in_cw, dd, dce, due, dloc);
            if (acc) begin
                m_ov = 1; m_d = dd; m_ce_o = dce; m_ue_o = due; m_loc = dloc;
            end else if (out_ready) begin
                m_ov = 0;
            end
            if (m_wb) begin
                if (wb_ready) m_wb = 0;
            end else if (acc && dce && scrub_en) begin
                m_wb = 1; m_wba = in_addr; m_wbcw = m_enc(dd);
            end
            if (cnt_clr) begin
                m_ce = (acc && dce) ? 1 : 0;
                m_ue = (acc && due) ? 1 : 0;
                m_lv = 0;
            end else begin
                if (acc && dce) m_ce++;
                if (acc && due) m_ue++;
            end
            if (acc && (dce || due) && !m_lv) begin
                m_lv = 1; m_la = in_addr; m_lue = due; m_lloc = dloc;
            end
            @(posedge clk);
            #1;
            checks += 6;
            if (out_valid !== m_ov) begin errors++; $display("FAIL rnd_ovalid c=%0d got %b want %b", c, out_valid, m_ov); end
            if (m_ov && (out_data !== m_d || out_ce !== m_ce_o || out_ue !== m_ue_o || (m_ce_o && out_loc !== m_loc)))
                begin errors++; $display("FAIL rnd_out c=%0d got %h/%b/%b/%h want %h/%b/%b/%h", c, out_data, out_ce, out_ue, out_loc, m_d, m_ce_o, m_ue_o, m_loc); end
            if (wb_valid !== m_wb || (m_wb && (wb_addr !== m_wba || wb_cw !== m_wbcw)))
                begin errors++; $display("FAIL rnd_wb c=%0d got %b/%h/%h want %b/%h/%h", c, wb_valid, wb_addr, wb_cw, m_wb, m_wba, m_wbcw); end
            if (ce_cnt !== 16'((m_ce > 65535) ? 65535 : m_ce) || ue_cnt !== 16'((m_ue > 65535) ? 65535 : m_ue))
                begin errors++; $display("FAIL rnd_cnt c=%0d got %0d/%0d want %0d/%0d", c, ce_cnt, ue_cnt, m_ce, m_ue); end
            if (s_ce_cnt !== 2'((m_ce > 3) ? 3 : m_ce) || s_ue_cnt !== 2'((m_ue > 3) ? 3 : m_ue))
                begin errors++; $display("FAIL rnd_sat c=%0d got %0d/%0d want min3(%0d/%0d)", c, s_ce_cnt, s_ue_cnt, m_ce, m_ue); end
            if (first_err_valid !== m_lv || (m_lv && (first_err_addr !== m_la || first_err_ue !== m_lue || (!m_lue && first_err_loc !== m_lloc))))
                begin errors++; $display("FAIL rnd_log c=%0d got %b/%h/%b/%h want %b/%h/%b/%h", c, first_err_valid, first_err_addr, first_err_ue, first_err_loc, m_lv, m_la, m_lue, m_lloc); end
        end
        in_valid = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset_in_wb();
        out_ready = 1'b1;
        wb_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        wb_ready = 1'b0;
        push(10'd40, 16'h8003, 1'b1);
        checks++;
        if (wb_valid !== 1'b1) begin errors++; $display("FAIL rwb_pre got %b want 1", wb_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (wb_valid !== 1'b0) begin errors++; $display("FAIL rwb_wb got %b want 0", wb_valid); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rwb_out got %b want 0", out_valid); end
        if (ce_cnt !== 16'd0 || ue_cnt !== 16'd0 || s_ce_cnt !== 2'd0) begin errors++; $display("FAIL rwb_cnt got %0d/%0d want 0/0", ce_cnt, ue_cnt); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rwb_ready got %b want 0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks += 2;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rwb_release got %b want 1", in_ready); end
        if (wb_valid !== 1'b0 || first_err_valid !== 1'b0) begin errors++; $display("FAIL rwb_after got wb=%b log=%b want 0 0", wb_valid, first_err_valid); end
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_double();
        test_parity();
        test_backpressure();
        test_saturation();
        test_random();
        test_reset_in_wb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
